// File: rtl/comparador_blink_leds.sv
// LED presentation stage for the 3-bit magnitude comparator: registers the 12-bit result and drives the LEDs.
// Define COMPARADOR_BLINK_BURST_EN to compile in the attention burst that flashes the bank on every change.
module comparador_blink_leds #(
    parameter int unsigned TICK_DIV    = 12_500_000,
    parameter int unsigned BURST_TICKS = 6,
    parameter bit          ACTIVE_LOW  = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] cmp_in,
    output logic [11:0] led,
    output logic        busy
);

    localparam int unsigned      DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [11:0]      LED_RST  = ACTIVE_LOW ? 12'hFFF : 12'h000;

    if (TICK_DIV < 2 || BURST_TICKS < 1) begin : g_bad_cfg
        $error("comparador_blink_leds: TICK_DIV must be >= 2 and BURST_TICKS >= 1");
    end

    logic [11:0]      cmp_q;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_cnt_d;
    logic [1:0]       ph;
    logic [1:0]       ph_d;
    logic [11:0]      disp;
    logic [11:0]      disp_idle;
    logic             tick;
    logic             fast;
    logic             slow;

    assign tick = (div_cnt == DIV_LAST);
    assign fast = ph[0];
    assign slow = ph[1];

    // Less blinks fast, equal is steady, greater blinks slow; detail bits are always steady.
    assign disp_idle = {cmp_q[11] & slow, cmp_q[10], cmp_q[9] & fast, cmp_q[8:0]};

`ifdef COMPARADOR_BLINK_BURST_EN

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int unsigned BCNT_W = $clog2(BURST_TICKS + 1);

    state_t            state;
    state_t            state_d;
    logic [BCNT_W-1:0] bcnt;
    logic [BCNT_W-1:0] bcnt_d;
    logic              change;

    assign change = (cmp_in != cmp_q);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state;
        bcnt_d    = bcnt;
        div_cnt_d = tick ? '0 : div_cnt + 1'b1;
        ph_d      = tick ? ph + 2'd1 : ph;
        disp      = disp_idle;

        case (state)
            BURST: begin
                disp = fast ? cmp_q : 12'h000;
                if (tick) begin
                    bcnt_d = bcnt - 1'b1;
                    if (bcnt == BCNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: ;
        endcase

        // A change (re)starts the burst and wins over a burst-ending tick on the same edge.
        if (change) begin
            state_d   = BURST;
            div_cnt_d = '0;
            ph_d      = 2'b11;
            bcnt_d    = BCNT_W'(BURST_TICKS);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            bcnt  <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_d;
            bcnt  <= bcnt_d;
            busy  <= (state == BURST);
        end
    end

`else

    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt + 1'b1;
        ph_d      = tick ? ph + 2'd1 : ph;
        disp      = disp_idle;
    end

    assign busy = 1'b0;

`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_q   <= '0;
            div_cnt <= '0;
            ph      <= '0;
            led     <= LED_RST;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            cmp_q   <= cmp_in;
            div_cnt <= div_cnt_d;
            ph      <= ph_d;
            led     <= ACTIVE_LOW ? ~disp : disp;
        end
    end

endmodule

// File: tb/tb_comparador_blink_leds.sv
// Scoreboard bench for comparador_blink_leds: a time-based reference model predicts led/busy per cycle.
// Runs both ACTIVE_LOW polarities side by side; follows COMPARADOR_BLINK_BURST_EN like the design.
module tb_comparador_blink_leds;

    localparam int TD = 4;
    localparam int BT = 3;
`ifdef COMPARADOR_BLINK_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    typedef struct {
        logic [11:0] disp;
        logic        busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [11:0] cmp_in = 12'h000;
    logic [11:0] led_h;
    logic [11:0] led_l;
    logic        busy_h;
    logic        busy_l;

    int   checks = 0;
    int   failures = 0;
    bit   done = 1'b0;
    exp_t exp_q[$];

    // Reference model state: edges since reset release, last sampled word, phase anchor.
    int          m;
    logic [11:0] q;
    int          anchor;
    int          ph0;
    int          last_chg;
    bit          have_chg;

    always #5 clk = ~clk;

    comparador_blink_leds #(.TICK_DIV(TD), .BURST_TICKS(BT), .ACTIVE_LOW(1'b0)) u_dut_h (
        .clk(clk), .rst_n(rst_n), .cmp_in(cmp_in), .led(led_h), .busy(busy_h)
    );

    comparador_blink_leds #(.TICK_DIV(TD), .BURST_TICKS(BT), .ACTIVE_LOW(1'b1)) u_dut_l (
        .clk(clk), .rst_n(rst_n), .cmp_in(cmp_in), .led(led_l), .busy(busy_l)
    );

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
        end
    endtask

    // Phase = start phase plus whole ticks elapsed since the anchor; burst = within BT*TD edges of a change.
    function automatic exp_t model_out();
        exp_t e;
        int   ph;
        bit   burst;
        ph    = (ph0 + (m - anchor) / TD) % 4;
        burst = BURST_EN && have_chg && ((m - last_chg) < BT * TD);
        if (burst) begin
            e.disp = (ph % 2 == 1) ? q : 12'h000;
        end else begin
            e.disp      = q;
            e.disp[9]   = q[9] & (ph % 2 == 1);
            e.disp[11]  = q[11] & (ph / 2 == 1);
        end
        e.busy = burst;
        return e;
    endfunction

    task automatic model_edge(input logic [11:0] v);
        m++;
        if (BURST_EN && (v != q)) begin
            last_chg = m;
            have_chg = 1'b1;
            anchor   = m;
            ph0      = 3;
        end
        q = v;
        exp_q.push_back(model_out());
    endtask

    task automatic release_reset();
        exp_t e0;
        m        = 0;
        q        = 12'h000;
        anchor   = 0;
        ph0      = 0;
        last_chg = 0;
        have_chg = 1'b0;
        exp_q.delete();
        e0.disp = 12'h000;
        e0.busy = 1'b0;
        exp_q.push_back(e0);
        exp_q.push_back(model_out());
        rst_n = 1'b1;
    endtask

    task automatic cycle(input logic [11:0] v);
        cmp_in = v;
        @(posedge clk);
        model_edge(v);
        #1;
    endtask

    task automatic hold(input logic [11:0] v, input int n);
        for (int i = 0; i < n; i++) cycle(v);
    endtask

    // Monitor: reset values while rst_n is low, otherwise pop the scoreboard once per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) break;
            if (!rst_n) begin
                check("rst_led", led_h, 12'h000);
                check("rst_led_al", led_l, 12'hFFF);
                check("rst_busy", {11'b0, busy_h}, 12'h000);
                check("rst_busy_al", {11'b0, busy_l}, 12'h000);
            end else if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty t=%0t got=none want=entry", $time);
            end else begin
                e = exp_q.pop_front();
                check("led", led_h, e.disp);
                check("led_al", led_l, ~e.disp);
                check("busy", {11'b0, busy_h}, {11'b0, e.busy});
                check("busy_al", {11'b0, busy_l}, {11'b0, e.busy});
            end
        end
    end

    initial begin
        logic [11:0] v;
        cmp_in = 12'h9C0;
        #1 rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        release_reset();

        hold(12'h438, 20);
        hold(12'h207, 30);
        hold(12'h9C0, 40);
        hold(12'h438, 6);
        hold(12'h207, 20);
        hold(12'h000, 16);
        hold(12'h438, 12);
        hold(12'h207, 20);
        hold(12'hE00, 30);

        for (int s = 0; s < 40; s++) begin
            v = ($urandom_range(0, 3) == 0) ? cmp_in : 12'($urandom);
            hold(v, $urandom_range(1, 16));
        end

        hold(12'h123, 5);
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        release_reset();
        hold(12'h123, 20);

        for (int s = 0; s < 20; s++) begin
            v = 12'($urandom);
            hold(v, $urandom_range(1, 16));
        end

        done = 1'b1;
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
